// File: rtl/iob_clint_mh.sv
// Multi-hart RISC-V core-local interruptor (CLINT).
// Holds the 64-bit mtime counter plus per-hart mtimecmp and msip registers
// behind a 32-bit valid/ready slave port, and drives per-hart mtip/msip.
module iob_clint_mh #(
    parameter int N_CORES     = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int MTIME_SRC   = 0,
    parameter int CLK_DIV     = 100,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rtc,
    input  logic                  valid,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic [N_CORES-1:0]    mtip,
    output logic [N_CORES-1:0]    msip
);

    localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    localparam logic [31:0] MSIP_BASE = 32'h0000_0000;
    localparam logic [31:0] CMP_BASE  = 32'h0000_4000;
    localparam logic [31:0] MTIME_LO  = 32'h0000_BFF8;
    localparam logic [31:0] MTIME_HI  = 32'h0000_BFFC;

    logic [63:0]          mtime;
    logic [63:0]          mtimecmp [N_CORES];
    logic [31:0]          mtime_hi_shadow;
    logic [PRESC_W-1:0]   prescaler;
    logic [SYNC_STAGES-1:0] rtc_sync;
    logic                 rtc_prev;
    logic                 rtc_tick;
    logic                 presc_tick;
    logic                 tick;

    logic [31:0]          addr_full;
    logic                 is_write;
    logic                 is_read;
    logic                 sel_mtime_lo;
    logic                 sel_mtime_hi;
    logic [N_CORES-1:0]   sel_msip;
    logic [N_CORES-1:0]   sel_cmp_lo;
    logic [N_CORES-1:0]   sel_cmp_hi;
    logic [31:0]          read_value;

    // Merge write data into an existing word, one byte per strobe bit.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // Address decode and read-data mux; reads see register contents before any same-edge write.
    always_comb begin
        addr_full    = 32'(address);
        is_write     = valid && (wstrb != '0);
        is_read      = valid && (wstrb == '0);
        sel_mtime_lo = (addr_full == MTIME_LO);
        sel_mtime_hi = (addr_full == MTIME_HI);
        sel_msip     = '0;
        sel_cmp_lo   = '0;
        sel_cmp_hi   = '0;
        read_value   = '0;
        if (sel_mtime_lo) read_value = mtime[31:0];
        if (sel_mtime_hi) read_value = mtime_hi_shadow;
        for (int h = 0; h < N_CORES; h++) begin
            if (addr_full == MSIP_BASE + 32'(4 * h)) begin
                sel_msip[h] = 1'b1;
                read_value  = {31'b0, msip[h]};
            end
            if (addr_full == CMP_BASE + 32'(8 * h)) begin
                sel_cmp_lo[h] = 1'b1;
                read_value    = mtimecmp[h][31:0];
            end
            if (addr_full == CMP_BASE + 32'(8 * h + 4)) begin
                sel_cmp_hi[h] = 1'b1;
                read_value    = mtimecmp[h][63:32];
            end
        end
    end

    // rtc synchroniser chain plus one extra flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rtc_sync <= '0;
            rtc_prev <= 1'b0;
        end else begin
            rtc_sync <= {rtc_sync[SYNC_STAGES-2:0], rtc};
            rtc_prev <= rtc_sync[SYNC_STAGES-1];
        end
    end

    // Clock prescaler counting 0..CLK_DIV-1, ticking on the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
        end else if (prescaler == PRESC_LAST) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    assign rtc_tick   = rtc_sync[SYNC_STAGES-1] & ~rtc_prev;
    assign presc_tick = (prescaler == PRESC_LAST);
    assign tick       = (MTIME_SRC == 0) ? rtc_tick : presc_tick;

    // mtime counter; a bus write to either half takes priority over a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= '0;
        end else if (is_write && sel_mtime_lo) begin
            mtime[31:0] <= merge_bytes(mtime[31:0], wdata, wstrb);
        end else if (is_write && sel_mtime_hi) begin
            mtime[63:32] <= merge_bytes(mtime[63:32], wdata, wstrb);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // Latch the upper mtime half when the lower half is read so lo/hi pairs are coherent.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_hi_shadow <= '0;
        end else if (is_read && sel_mtime_lo) begin
            mtime_hi_shadow <= mtime[63:32];
        end
    end

    // Per-hart mtimecmp and msip registers plus the registered timer compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int h = 0; h < N_CORES; h++) begin
                mtimecmp[h] <= '1;
            end
            msip <= '0;
            mtip <= '0;
        end else begin
            for (int h = 0; h < N_CORES; h++) begin
                if (is_write && sel_cmp_lo[h])
                    mtimecmp[h][31:0] <= merge_bytes(mtimecmp[h][31:0], wdata, wstrb);
                if (is_write && sel_cmp_hi[h])
                    mtimecmp[h][63:32] <= merge_bytes(mtimecmp[h][63:32], wdata, wstrb);
                if (is_write && sel_msip[h] && wstrb[0])
                    msip[h] <= wdata[0];
                mtip[h] <= (mtime >= mtimecmp[h]);
            end
        end
    end

    // Single-cycle bus response: every request completes on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= valid;
            rdata <= valid ? read_value : '0;
        end
    end

endmodule

// File: tb/tb_iob_clint_mh.sv
// Scoreboard testbench for iob_clint_mh: one rtc-driven instance and one
// prescaler-driven instance share the clock; bus responses are checked by
// per-instance monitors against queued expectations.
module tb_iob_clint_mh;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rtc_a, valid_a, ready_a;
    logic [15:0] address_a;
    logic [31:0] wdata_a, rdata_a;
    logic [3:0]  wstrb_a;
    logic [1:0]  mtip_a, msip_a;

    logic        rst_b, rtc_b, valid_b, ready_b;
    logic [15:0] address_b;
    logic [31:0] wdata_b, rdata_b;
    logic [3:0]  wstrb_b;
    logic [1:0]  mtip_b, msip_b;

    iob_clint_mh #(.N_CORES(2), .ADDR_W(16), .DATA_W(32), .MTIME_SRC(0),
                   .CLK_DIV(100), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst_a), .rtc(rtc_a), .valid(valid_a), .address(address_a),
        .wdata(wdata_a), .wstrb(wstrb_a), .rdata(rdata_a), .ready(ready_a),
        .mtip(mtip_a), .msip(msip_a));

    iob_clint_mh #(.N_CORES(2), .ADDR_W(16), .DATA_W(32), .MTIME_SRC(1),
                   .CLK_DIV(4), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst_b), .rtc(rtc_b), .valid(valid_b), .address(address_b),
        .wdata(wdata_b), .wstrb(wstrb_b), .rdata(rdata_b), .ready(ready_b),
        .mtip(mtip_b), .msip(msip_b));

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_a;
    exp_t mon_b;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one bus request (driven on a negedge) and queue its expected response.
    task automatic applyStimulus(input bit on_b, input logic [15:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input logic chk, input logic [31:0] exp,
                                 input string name);
        exp_t e;
        e.chk  = chk;
        e.exp  = exp;
        e.name = name;
        if (!on_b) begin
            valid_a = 1'b1; address_a = addr; wdata_a = data; wstrb_a = strb;
            q_a.push_back(e);
            @(negedge clk);
            valid_a = 1'b0; wstrb_a = 4'h0;
        end else begin
            valid_b = 1'b1; address_b = addr; wdata_b = data; wstrb_b = strb;
            q_b.push_back(e);
            @(negedge clk);
            valid_b = 1'b0; wstrb_b = 4'h0;
        end
    endtask

    task automatic wr(input bit on_b, input logic [15:0] addr, input logic [31:0] data,
                      input logic [3:0] strb);
        applyStimulus(on_b, addr, data, strb, 1'b0, 32'h0, "write");
    endtask

    task automatic rd(input bit on_b, input logic [15:0] addr, input logic [31:0] exp,
                      input string name);
        applyStimulus(on_b, addr, 32'h0, 4'h0, 1'b1, exp, name);
    endtask

    // One full rtc period, long enough for the synchroniser, tick and mtip update.
    task automatic rtc_pulse();
        rtc_a = 1'b1;
        repeat (4) @(negedge clk);
        rtc_a = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Monitor for instance A: every ready must match a queued request.
    always @(negedge clk) begin
        if (ready_a === 1'b1) begin
            if (q_a.size() == 0) begin
                checkOutput("unexpected_ready_a", 64'(ready_a), 64'd0);
            end else begin
                mon_a = q_a.pop_front();
                if (mon_a.chk) checkOutput(mon_a.name, 64'(rdata_a), 64'(mon_a.exp));
            end
        end
    end

    // Monitor for instance B.
    always @(negedge clk) begin
        if (ready_b === 1'b1) begin
            if (q_b.size() == 0) begin
                checkOutput("unexpected_ready_b", 64'(ready_b), 64'd0);
            end else begin
                mon_b = q_b.pop_front();
                if (mon_b.chk) checkOutput(mon_b.name, 64'(rdata_b), 64'(mon_b.exp));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_a = 1'b1; rtc_a = 1'b0; valid_a = 1'b0; address_a = '0; wdata_a = '0; wstrb_a = '0;
        rst_b = 1'b1; rtc_b = 1'b0; valid_b = 1'b0; address_b = '0; wdata_b = '0; wstrb_b = '0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;

        // Reset state
        checkOutput("reset_ready", 64'(ready_a), 64'd0);
        checkOutput("reset_rdata", 64'(rdata_a), 64'd0);
        checkOutput("reset_mtip",  64'(mtip_a),  64'd0);
        checkOutput("reset_msip",  64'(msip_a),  64'd0);
        rd(0, 16'hBFF8, 32'h0, "reset_mtime_lo");
        rd(0, 16'hBFFC, 32'h0, "reset_mtime_hi");
        rd(0, 16'h400C, 32'hFFFF_FFFF, "reset_cmp1_hi");

        // Timer compare for hart 0
        wr(0, 16'h4000, 32'd20, 4'hF);
        wr(0, 16'h4004, 32'd0,  4'hF);
        repeat (19) rtc_pulse();
        checkOutput("mtip_before_20", 64'(mtip_a), 64'd0);
        rtc_pulse();
        checkOutput("mtip_at_20", 64'(mtip_a), 64'b01);
        wr(0, 16'h4000, 32'hFFFF_FFFF, 4'hF);
        repeat (2) @(negedge clk);
        checkOutput("mtip_after_raise_cmp", 64'(mtip_a), 64'd0);
        rd(0, 16'h4000, 32'hFFFF_FFFF, "cmp0_lo");
        rd(0, 16'h4004, 32'h0, "cmp0_hi");

        // Software interrupts
        wr(0, 16'h0004, 32'h1, 4'hF);
        checkOutput("msip_set_h1", 64'(msip_a), 64'b10);
        rd(0, 16'h0004, 32'h1, "msip1_read");
        wr(0, 16'h0004, 32'h0, 4'hF);
        checkOutput("msip_clear_h1", 64'(msip_a), 64'b00);
        wr(0, 16'h0008, 32'h1, 4'hF);
        checkOutput("msip_unmapped_h2", 64'(msip_a), 64'b00);
        rd(0, 16'h0008, 32'h0, "msip2_read");

        // Coherent mtime read across a carry into the upper half
        wr(0, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        wr(0, 16'hBFFC, 32'h0, 4'hF);
        rtc_pulse();
        rd(0, 16'hBFF8, 32'h0, "carry_lo");
        rd(0, 16'hBFFC, 32'h1, "carry_hi");
        rtc_pulse();
        rd(0, 16'hBFFC, 32'h1, "shadow_hi");
        rd(0, 16'hBFF8, 32'h1, "after_tick_lo");

        // Byte strobes
        wr(0, 16'h4000, 32'h0000_0055, 4'b0001);
        rd(0, 16'h4000, 32'hFFFF_FF55, "strobe_byte0");
        repeat (2) @(negedge clk);
        checkOutput("mtip_low_cmp", 64'(mtip_a), 64'b01);
        wr(0, 16'h4004, 32'hAB00_0000, 4'b1000);
        rd(0, 16'h4004, 32'hAB00_0000, "strobe_byte3");
        repeat (2) @(negedge clk);
        checkOutput("mtip_high_cmp", 64'(mtip_a), 64'b00);

        // Unmapped addresses
        wr(0, 16'h4010, 32'h1234_5678, 4'hF);
        rd(0, 16'h4010, 32'h0, "unmapped_cmp2");
        rd(0, 16'h8000, 32'h0, "unmapped_8000");
        rd(0, 16'h4008, 32'hFFFF_FFFF, "cmp1_lo_untouched");

        // mtime wrap at all-ones; equality counts as expired
        wr(0, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
        wr(0, 16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        repeat (2) @(negedge clk);
        checkOutput("mtip_all_ones", 64'(mtip_a), 64'b11);
        rtc_pulse();
        rd(0, 16'hBFF8, 32'h0, "wrap_lo");
        rd(0, 16'hBFFC, 32'h0, "wrap_hi");
        checkOutput("mtip_after_wrap", 64'(mtip_a), 64'b00);

        // Prescaler-driven instance: CLK_DIV=4
        rst_b = 1'b0;
        repeat (40) @(negedge clk);
        rd(1, 16'hBFF8, 32'd10, "presc_mtime_40clk");
        rd(1, 16'h8000, 32'h0, "presc_unmapped");

        // Reset asserted together with a request drops it
        valid_b = 1'b1; address_b = 16'hBFF8; wstrb_b = 4'h0; rst_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0;
        checkOutput("rst_drop_ready", 64'(ready_b), 64'd0);
        @(negedge clk);
        rst_b = 1'b0;
        checkOutput("rst_hold_ready", 64'(ready_b), 64'd0);
        rd(1, 16'hBFF8, 32'h0, "presc_after_reset");

        // Drain outstanding responses
        repeat (3) @(negedge clk);
        if (q_a.size() != 0) checkOutput("pending_a", 64'(q_a.size()), 64'd0);
        if (q_b.size() != 0) checkOutput("pending_b", 64'(q_b.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
